// File: rtl/spi_ctrl_tx_if.sv
// Request handshake and SPI pin bundle for spi_ctrl_tx.
// Defining SPI_CTRL_CIPO_EN adds the cipo input and the rx_data readback.
interface spi_ctrl_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       busy;
  logic       done;
`ifdef SPI_CTRL_CIPO_EN
  logic       cipo;
  logic [7:0] rx_data;
`endif

  // Requester side: issues frames and watches the pins.
  modport master (
    output req_valid, req_rw, req_addr, req_data,
    input  req_ready, sclk, copi, ncs, busy, done
`ifdef SPI_CTRL_CIPO_EN
    , output cipo,
    input  rx_data
`endif
  );

  // Controller side: accepts frames and drives the SPI pins.
  modport slave (
    input  req_valid, req_rw, req_addr, req_data,
    output req_ready, sclk, copi, ncs, busy, done
`ifdef SPI_CTRL_CIPO_EN
    , input cipo,
    output rx_data
`endif
  );
endinterface

// File: rtl/spi_ctrl_tx.sv
// Mode-0 SPI controller shifting 16-bit {rw, addr, data} frames out MSB first.
// Optional readback capture of the data byte is enabled by defining SPI_CTRL_CIPO_EN.
module spi_ctrl_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic         clk,
  input  logic         rst,
  spi_ctrl_tx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  state_t      state, state_nxt;
  logic [7:0]  div_cnt, div_nxt;
  logic [3:0]  bit_cnt, bit_nxt;
  logic [15:0] shreg, shreg_nxt;
  logic        sclk_q, sclk_nxt;
  logic        ncs_q, ncs_nxt;
  logic        done_q, done_nxt;
  logic        div_end;

`ifdef SPI_CTRL_CIPO_EN
  logic [7:0]  rx_shift, rx_shift_nxt;
  logic [7:0]  rx_q, rx_nxt;
`endif

  assign div_end = (div_cnt == DIV_LAST);

  // copi is the shift register MSB, so clearing the register idles copi low.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    sclk_nxt  = sclk_q;
    ncs_nxt   = ncs_q;
    done_nxt  = 1'b0;
`ifdef SPI_CTRL_CIPO_EN
    rx_shift_nxt = rx_shift;
    rx_nxt       = rx_q;
`endif
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          state_nxt = SETUP;
          shreg_nxt = {bus.req_rw, bus.req_addr, bus.req_data};
          div_nxt   = '0;
          bit_nxt   = '0;
          ncs_nxt   = 1'b0;
          sclk_nxt  = 1'b0;
        end
      end
      SETUP: begin
        if (div_end) begin
          state_nxt = SHIFT;
          div_nxt   = '0;
          sclk_nxt  = 1'b1;
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (!div_end) begin
          div_nxt = div_cnt + 8'd1;
        end else begin
          div_nxt = '0;
          if (sclk_q) begin
            sclk_nxt  = 1'b0;
            shreg_nxt = {shreg[14:0], 1'b0};
          end else if (bit_cnt == LAST_BIT) begin
            state_nxt = GAP;
            ncs_nxt   = 1'b1;
            shreg_nxt = '0;
            done_nxt  = 1'b1;
`ifdef SPI_CTRL_CIPO_EN
            rx_nxt    = rx_shift;
`endif
          end else begin
            sclk_nxt = 1'b1;
            bit_nxt  = bit_cnt + 4'd1;
`ifdef SPI_CTRL_CIPO_EN
            // Peripheral drives the read byte during frame bits 7..0.
            if (bit_cnt >= 4'd7) begin
              rx_shift_nxt = {rx_shift[6:0], bus.cipo};
            end
`endif
          end
        end
      end
      GAP: begin
        if (div_end) begin
          state_nxt = IDLE;
          div_nxt   = '0;
        end else begin
          div_nxt = div_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      sclk_q  <= sclk_nxt;
      ncs_q   <= ncs_nxt;
      done_q  <= done_nxt;
    end
  end

`ifdef SPI_CTRL_CIPO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift <= '0;
      rx_q     <= '0;
    end else begin
      rx_shift <= rx_shift_nxt;
      rx_q     <= rx_nxt;
    end
  end

  assign bus.rx_data = rx_q;
`endif

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.sclk      = sclk_q;
  assign bus.copi      = shreg[15];
  assign bus.ncs       = ncs_q;
  assign bus.done      = done_q;

endmodule
